// File: rtl/exec_wb_unit.sv
// exec_wb_unit: multi-cycle execute/writeback engine for a 16-entry register file.
// A request is accepted in IDLE, its sources are read from the register file,
// the ALU (or an iterative shift-add multiplier) produces a result, and the result
// is presented for one writeback cycle together with zero/overflow flags.
//
// Ports:
//   Clk, Rst               clock and synchronous active-high reset
//   Start, OP              request and 4-bit opcode (sampled only in IDLE)
//   Rs_Addr/Rt_Addr/Rd_Addr  source A, source B and destination register numbers
//   R_Data_A/R_Data_B      register-file read data (combinational from R_Addr_A/B)
//   R_Addr_A/R_Addr_B      register-file read addresses
//   Write_Reg, W_Addr, W_Data  register-file write port (valid in WB only)
//   Busy                   high whenever an operation is in flight
//   Done, Err              one-cycle completion pulse and invalid-opcode flag
//   ZF, OF                 zero / signed-overflow flags of the last valid operation
module exec_wb_unit #(
    parameter int ADDR = 4,
    parameter int SIZE = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic [3:0]      OP,
    input  logic [ADDR-1:0] Rs_Addr,
    input  logic [ADDR-1:0] Rt_Addr,
    input  logic [ADDR-1:0] Rd_Addr,
    input  logic [SIZE-1:0] R_Data_A,
    input  logic [SIZE-1:0] R_Data_B,
    output logic [ADDR-1:0] R_Addr_A,
    output logic [ADDR-1:0] R_Addr_B,
    output logic            Write_Reg,
    output logic [ADDR-1:0] W_Addr,
    output logic [SIZE-1:0] W_Data,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic            ZF,
    output logic            OF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam logic [4:0] MUL_LAST = 5'd31;

    state_t          state_r;
    logic [3:0]      op_r;
    logic [ADDR-1:0] rd_r;
    logic [SIZE-1:0] op_a_r;
    logic [SIZE-1:0] op_b_r;
    logic [SIZE-1:0] acc_r;
    logic [4:0]      cnt_r;

    logic [SIZE-1:0] sum_s;
    logic [SIZE-1:0] diff_s;
    logic [SIZE-1:0] mul_next_s;
    logic [SIZE-1:0] alu_res_s;
    logic            alu_of_s;
    logic            op_valid_s;
    logic            mul_step_s;

    // Signed overflow of a + b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a - b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    // ALU result, flags, opcode validity and the next multiplier partial sum.
    always_comb begin
        sum_s      = op_a_r + op_b_r;
        diff_s     = op_a_r - op_b_r;
        // Multiplicand op_a_r shifts left, multiplier op_b_r shifts right each step.
        mul_next_s = acc_r + (op_b_r[0] ? op_a_r : {SIZE{1'b0}});
        mul_step_s = (op_r == OP_MUL) && (cnt_r != MUL_LAST);
        alu_res_s  = {SIZE{1'b0}};
        alu_of_s   = 1'b0;
        op_valid_s = 1'b1;
        case (op_r)
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_of_s  = add_ovf(op_a_r[SIZE-1], op_b_r[SIZE-1], sum_s[SIZE-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_of_s  = sub_ovf(op_a_r[SIZE-1], op_b_r[SIZE-1], diff_s[SIZE-1]);
            end
            OP_AND:  alu_res_s = op_a_r & op_b_r;
            OP_OR:   alu_res_s = op_a_r | op_b_r;
            OP_XOR:  alu_res_s = op_a_r ^ op_b_r;
            OP_NOR:  alu_res_s = ~(op_a_r | op_b_r);
            OP_SLT:  alu_res_s = {{(SIZE-1){1'b0}}, ($signed(op_a_r) < $signed(op_b_r))};
            OP_SLL:  alu_res_s = op_b_r << op_a_r[4:0];
            // The final (32nd) shift-add step is folded into the writeback edge.
            OP_MUL:  alu_res_s = mul_next_s;
            default: op_valid_s = 1'b0;
        endcase
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            op_r      <= 4'd0;
            rd_r      <= {ADDR{1'b0}};
            op_a_r    <= {SIZE{1'b0}};
            op_b_r    <= {SIZE{1'b0}};
            acc_r     <= {SIZE{1'b0}};
            cnt_r     <= 5'd0;
            R_Addr_A  <= {ADDR{1'b0}};
            R_Addr_B  <= {ADDR{1'b0}};
            Write_Reg <= 1'b0;
            W_Addr    <= {ADDR{1'b0}};
            W_Data    <= {SIZE{1'b0}};
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            ZF        <= 1'b0;
            OF        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        op_r     <= OP;
                        rd_r     <= Rd_Addr;
                        R_Addr_A <= Rs_Addr;
                        R_Addr_B <= Rt_Addr;
                        Busy     <= 1'b1;
                        state_r  <= READ;
                    end
                end
                READ: begin
                    // Operands are snapshotted here, so Rd may alias Rs/Rt safely.
                    op_a_r  <= R_Data_A;
                    op_b_r  <= R_Data_B;
                    acc_r   <= {SIZE{1'b0}};
                    cnt_r   <= 5'd0;
                    state_r <= EXEC;
                end
                EXEC: begin
                    if (mul_step_s) begin
                        acc_r  <= mul_next_s;
                        op_a_r <= op_a_r << 1;
                        op_b_r <= op_b_r >> 1;
                        cnt_r  <= cnt_r + 5'd1;
                    end else begin
                        state_r   <= WB;
                        Done      <= 1'b1;
                        W_Addr    <= rd_r;
                        Write_Reg <= op_valid_s;
                        Err       <= ~op_valid_s;
                        // Invalid opcodes leave data and flags untouched.
                        if (op_valid_s) begin
                            W_Data <= alu_res_s;
                            ZF     <= (alu_res_s == {SIZE{1'b0}});
                            OF     <= alu_of_s;
                        end
                    end
                end
                WB: begin
                    Done      <= 1'b0;
                    Write_Reg <= 1'b0;
                    Err       <= 1'b0;
                    Busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_wb_unit.sv
// tb_exec_wb_unit: drives exec_wb_unit against a bench-owned register file and
// compares every completion with an arithmetic reference model.
module tb_exec_wb_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [3:0]  OP;
    logic [3:0]  Rs_Addr, Rt_Addr, Rd_Addr;
    logic [31:0] R_Data_A, R_Data_B;
    logic [3:0]  R_Addr_A, R_Addr_B;
    logic        Write_Reg;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Busy, Done, Err, ZF, OF;

    always #5 Clk = ~Clk;

    exec_wb_unit #(.ADDR(4), .SIZE(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .OP(OP),
        .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Rd_Addr(Rd_Addr),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
        .Busy(Busy), .Done(Done), .Err(Err), .ZF(ZF), .OF(OF)
    );

    // Register file environment with a backdoor load port.
    logic [31:0] rf [16];
    logic        bd_we;
    logic [3:0]  bd_addr;
    logic [31:0] bd_data;
    assign R_Data_A = rf[R_Addr_A];
    assign R_Data_B = rf[R_Addr_B];
    always @(posedge Clk) begin
        if (Write_Reg === 1'b1) rf[W_Addr] <= W_Data;
        else if (bd_we) rf[bd_addr] <= bd_data;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        err;
        logic        zf;
        logic        of_f;
        int          done_cyc;
        int          busy_len;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [16];
    logic [31:0] m_wdata;
    logic        m_zf, m_of;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the model register array.
    task automatic push_expected(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                                 input logic [3:0] rd, input int issue_cyc);
        logic [31:0] a, b, res;
        logic [63:0] p;
        logic        valid, of_f;
        int          sa, sbv, lat;
        longint      w;
        exp_t        e;
        a = mdl[rs]; b = mdl[rt]; sa = a; sbv = b;
        valid = 1'b1; of_f = 1'b0; res = 32'd0;
        case (op)
            4'd0: begin
                w = longint'(sa) + longint'(sbv);
                res = a + b;
                of_f = (w > 64'sd2147483647) || (w < -64'sd2147483648);
            end
            4'd1: begin
                w = longint'(sa) - longint'(sbv);
                res = a - b;
                of_f = (w > 64'sd2147483647) || (w < -64'sd2147483648);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~(a | b);
            4'd6: res = (sa < sbv) ? 32'd1 : 32'd0;
            4'd7: res = b << a[4:0];
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                res = p[31:0];
            end
            default: valid = 1'b0;
        endcase
        if (valid) begin
            mdl[rd] = res;
            m_wdata = res;
            m_zf = (res == 32'd0);
            m_of = of_f;
        end
        lat = (op == 4'd8) ? 33 : 2;
        e.wr = valid; e.addr = rd; e.data = m_wdata; e.err = ~valid;
        e.zf = m_zf; e.of_f = m_of; e.done_cyc = issue_cyc + lat; e.busy_len = lat + 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((Busy !== 1'b0 || sb.size() != 0) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (Busy !== 1'b0 || sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b pending=%0d required idle within 200 cycles", Busy, sb.size());
        end
    endtask

    task automatic set_reg(input logic [3:0] idx, input logic [31:0] val);
        wait_idle();
        bd_we = 1'b1; bd_addr = idx; bd_data = val; mdl[idx] = val;
        @(negedge Clk);
        bd_we = 1'b0;
    endtask

    task automatic drive_start(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                               input logic [3:0] rd);
        Start = 1'b1; OP = op; Rs_Addr = rs; Rt_Addr = rt; Rd_Addr = rd;
    endtask

    task automatic scramble();
        Start = 1'b0; OP = 4'($urandom); Rs_Addr = 4'($urandom);
        Rt_Addr = 4'($urandom); Rd_Addr = 4'($urandom);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd);
        wait_idle();
        push_expected(op, rs, rt, rd, cyc + 1);
        drive_start(op, rs, rt, rd);
        @(negedge Clk);
        scramble();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, Busy, 32'd0);
        check({tag, "_done"}, Done, 32'd0);
        check({tag, "_write_reg"}, Write_Reg, 32'd0);
        check({tag, "_err"}, Err, 32'd0);
        check({tag, "_zf"}, ZF, 32'd0);
        check({tag, "_of"}, OF, 32'd0);
        check({tag, "_w_data"}, W_Data, 32'd0);
        check({tag, "_w_addr"}, W_Addr, 32'd0);
        check({tag, "_r_addr_a"}, R_Addr_A, 32'd0);
        check({tag, "_r_addr_b"}, R_Addr_B, 32'd0);
    endtask

    // Monitor: pops and compares on every Done.
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge Clk);
            if (Busy === 1'b1) busy_run++;
            else busy_run = 0;
            if (prev_done) check("busy_after_done", Busy, 32'd0);
            if (Write_Reg === 1'b1 && Done !== 1'b1) check("write_without_done", Write_Reg, 32'd0);
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", Done, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("write_reg", Write_Reg, mon_e.wr);
                    check("w_addr", W_Addr, mon_e.addr);
                    check("w_data", W_Data, mon_e.data);
                    check("err", Err, mon_e.err);
                    check("zf", ZF, mon_e.zf);
                    check("of", OF, mon_e.of_f);
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("busy_len", busy_run, mon_e.busy_len);
                end
            end
            prev_done = (Done === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] saved;

    initial begin
        Rst = 1'b1; Start = 1'b0; OP = 4'd0; Rs_Addr = 4'd0; Rt_Addr = 4'd0; Rd_Addr = 4'd0;
        bd_we = 1'b0; bd_addr = 4'd0; bd_data = 32'd0;
        m_wdata = 32'd0; m_zf = 1'b0; m_of = 1'b0;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Rst = 1'b0;
        for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

        // Signed-overflow ADD.
        set_reg(4'd1, 32'h7FFF_FFFF);
        set_reg(4'd2, 32'h0000_0001);
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        wait_idle();
        check("add_ovf_rf3", rf[3], 32'h8000_0000);
        check("add_ovf_of", OF, 32'd1);

        // SUB to zero, then signed SLT.
        set_reg(4'd4, 32'd5);
        set_reg(4'd5, 32'd5);
        issue(4'd1, 4'd4, 4'd5, 4'd8);
        wait_idle();
        check("sub_zero_zf", ZF, 32'd1);
        set_reg(4'd6, 32'hFFFF_FFFF);
        set_reg(4'd7, 32'd1);
        issue(4'd6, 4'd6, 4'd7, 4'd9);
        wait_idle();
        check("sub_zero_rf8", rf[8], 32'd0);
        check("slt_rf9", rf[9], 32'd1);

        // MUL.
        set_reg(4'd1, 32'h0001_0001);
        set_reg(4'd2, 32'h0001_0001);
        issue(4'd8, 4'd1, 4'd2, 4'd10);
        wait_idle();
        check("mul_rf10", rf[10], 32'h0002_0001);

        // Invalid opcode: no write, flags held.
        issue(4'hF, 4'd1, 4'd2, 4'd11);
        wait_idle();
        check("invalid_rf11", rf[11], mdl[11]);

        // Reset in the middle of a MUL.
        wait_idle();
        saved = mdl[12];
        push_expected(4'd8, 4'd1, 4'd2, 4'd12, cyc + 1);
        drive_start(4'd8, 4'd1, 4'd2, 4'd12);
        @(negedge Clk);
        scramble();
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        sb.delete();
        mdl[12] = saved; m_wdata = 32'd0; m_zf = 1'b0; m_of = 1'b0;
        check_all_zero("midreset");
        repeat (40) @(negedge Clk);
        check("midreset_rf12", rf[12], saved);

        // Start pulsed during EXEC is ignored; Rd aliases Rs/Rt.
        set_reg(4'd1, 32'd3);
        wait_idle();
        push_expected(4'd0, 4'd1, 4'd1, 4'd1, cyc + 1);
        drive_start(4'd0, 4'd1, 4'd1, 4'd1);
        @(negedge Clk);
        scramble();
        @(negedge Clk);
        drive_start(4'd8, 4'd2, 4'd2, 4'd13);
        @(negedge Clk);
        scramble();
        wait_idle();
        repeat (5) @(negedge Clk);
        check("alias_rf1", rf[1], 32'd6);

        // Start held high: second operation begins at the next IDLE sample.
        set_reg(4'd10, 32'd7);
        set_reg(4'd11, 32'd9);
        wait_idle();
        push_expected(4'd0, 4'd10, 4'd11, 4'd10, cyc + 1);
        push_expected(4'd0, 4'd10, 4'd11, 4'd10, cyc + 5);
        drive_start(4'd0, 4'd10, 4'd11, 4'd10);
        repeat (5) @(negedge Clk);
        scramble();
        wait_idle();
        check("held_start_rf10", rf[10], 32'd25);

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 10);
            op = (r <= 8) ? 4'(r) : 4'($urandom_range(9, 15));
            if ($urandom_range(0, 3) == 0) set_reg(4'($urandom_range(0, 15)), 32'($urandom_range(0, 3)));
            issue(op, 4'($urandom), 4'($urandom), 4'($urandom));
        end

        wait_idle();
        repeat (3) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_wb_unit.md
EXEC_WB_UNIT -- requirements
Module: exec_wb_unit

Interface
REQ-001 Parameter ADDR, default 4, register address width (16 registers).
REQ-002 Parameter SIZE, default 32, data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Clk  in  1  rising-edge clock; single clock domain.
REQ-005 Rst  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  request; sampled only in IDLE.
REQ-007 OP  in  4  opcode, captured with Start.
REQ-008 Rs_Addr, Rt_Addr, Rd_Addr  in  ADDR each  source A, source B, destination; captured with Start.
REQ-009 R_Data_A, R_Data_B  in  SIZE  combinational register-file read data.
REQ-010 R_Addr_A, R_Addr_B  out  ADDR  register-file read addresses.
REQ-011 Write_Reg  out  1  register-file write enable.
REQ-012 W_Addr  out  ADDR; W_Data  out  SIZE  write address and data.
REQ-013 Busy  out  1  high whenever state is not IDLE.
REQ-014 Done  out  1  one-cycle completion pulse.
REQ-015 Err  out  1  invalid opcode; valid only while Done=1.
REQ-016 ZF, OF  out  1 each  zero and signed-overflow flags of the last completed operation.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, EXEC and WB, with transitions IDLE->READ on Start=1, READ->EXEC, EXEC->WB (after 1 cycle, or 32 for MUL), and WB->IDLE.
REQ-018 When Start is sampled in IDLE at edge E0, the block SHALL register OP, Rs, Rt and Rd at E0; Start SHALL be ignored in every other state.
REQ-019 R_Addr_A/R_Addr_B SHALL be driven from the latched Rs/Rt, and R_Data_A/B SHALL be captured into internal operands at the READ->EXEC edge (E1).
REQ-020 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT (signed, result 1/0), 0111 SLL (B << A[4:0]), 1000 MUL; all others are invalid.
REQ-021 All arithmetic SHALL be modulo 2^SIZE, with carry-out discarded.
REQ-022 MUL SHALL be an iterative unsigned shift-add taking 32 EXEC cycles, driven by a 5-bit counter running 0..31, and SHALL return the low SIZE bits of the product.
REQ-023 Single-cycle ops SHALL latch their result at the EXEC->WB edge (E2).
REQ-024 In WB, Done SHALL be 1 and W_Addr/W_Data SHALL present Rd and the result.
REQ-025 Write_Reg SHALL be 1 only in WB and only for a valid opcode; the register file commits at the following edge.
REQ-026 Latency SHALL be: single-cycle op, Done/Write_Reg high between E2 and E3; MUL, between E33 and E34.
REQ-027 An invalid opcode SHALL follow the same timing as a single-cycle op, with Write_Reg=0, Err=1 during Done, and ZF/OF/W_Data unchanged.
REQ-028 ZF SHALL be (result==0), updated at the edge entering WB for valid ops and held otherwise.
REQ-029 OF SHALL be signed overflow for ADD/SUB and 0 for other valid ops, updated at the edge entering WB and held otherwise.
REQ-030 Rd=0 SHALL be written like any other register; register 0 is not hardwired.
REQ-031 Rd equal to Rs or Rt SHALL be legal, because operands are captured before writeback.
REQ-032 Start held high continuously SHALL start a new operation at the WB->IDLE edge +1 cycle, i.e. the next IDLE sample, with no back-to-back skip of IDLE.

Reset
REQ-033 When Rst=1 at a rising edge, the block SHALL go to IDLE and clear all outputs to 0 (R_Addr_A/B, W_Addr, W_Data, Write_Reg, Busy, Done, Err, ZF, OF), the MUL counter and the operands.
REQ-034 Reset SHALL take priority over Start and over any in-progress operation, and an aborted operation SHALL produce no later write or Done.
REQ-035 Write_Reg/Done SHALL be decoded from state, so Rst rising during a WB cycle does not retract that cycle's outputs; the state is IDLE after the edge.

Verification
REQ-036 Scenario, signed-overflow ADD: regs r1=0x7FFFFFFF, r2=1; Start OP=ADD Rs=1 Rt=2 Rd=3 at E0 -> Write_Reg=1, W_Addr=3, W_Data=0x80000000 between E2-E3; ZF=0, OF=1; Busy high E0..E3.
REQ-037 Scenario, SUB to zero and SLT: SUB r4=5, r5=5 -> W_Data=0, ZF=1, OF=0; SLT r6=0xFFFFFFFF, r7=1 -> W_Data=1.
REQ-038 Scenario, MUL: r1=0x00010001, r2=0x00010001 -> W_Data=0x00020001, Done exactly between E33-E34, Busy high for 34 cycles.
REQ-039 Scenario, invalid opcode: OP=1111 -> Done=1 and Err=1 between E2-E3, Write_Reg never 1, ZF/OF unchanged.
REQ-040 Scenario, reset mid-MUL: Rst=1 for one cycle at E10 of a MUL -> Busy=0 after E10, no Write_Reg/Done afterwards, all outputs 0.
REQ-041 Scenario, Start while Busy and source=destination: Start pulsed during EXEC is ignored (no second Done); Rd=Rs=1 with ADD r1+r1 where r1=3 -> W_Data=6.
